// File: rtl/fifo_singleport_banked.sv
// fifo_singleport_banked: FIFO spread round-robin over N_BANKS single-port
// SRAM banks. Each bank has a 2-entry prefetch buffer in front of it, so a
// push and a pop can both happen every cycle even though every bank has only
// one port. Includes valid/ready handshakes, an occupancy count and
// almost-full / almost-empty flags.
// N_BANKS and DEPTH/N_BANKS must both be powers of two and at least 2.
module fifo_singleport_banked #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int N_BANKS   = 2,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_valid_i,
    output logic                       wr_ready_o,
    input  logic [WIDTH-1:0]           data_i,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o
);

    localparam int BANK_DEPTH = DEPTH / N_BANKS;
    localparam int SELW       = $clog2(N_BANKS);
    localparam int PW         = $clog2(BANK_DEPTH);
    localparam int SCW        = $clog2(BANK_DEPTH + 1);
    localparam int CW         = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [SELW-1:0]  wrSel_q, wrSel_d;
    logic [SELW-1:0]  rdSel_q, rdSel_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push;
    logic             pop;
    logic [N_BANKS-1:0] bankValid;
    logic [WIDTH-1:0] bankHead [N_BANKS];

    // Accepting a write depends only on the registered count, never on a
    // same-cycle pop, so a full FIFO refuses a write even while it is read.
    assign wr_ready_o     = (count_q < DEPTH_C);
    assign push           = wr_valid_i & wr_ready_o;
    assign rd_valid_o     = bankValid[rdSel_q];
    assign pop            = rd_valid_o & rd_ready_i;
    assign data_o         = rd_valid_o ? bankHead[rdSel_q] : '0;
    assign count_o        = count_q;
    assign almost_full_o  = (count_q >= AF_C);
    assign almost_empty_o = (count_q <= AE_C);

    // Next-state for the bank selectors and occupancy count.
    always_comb begin
        wrSel_d = wrSel_q;
        rdSel_d = rdSel_q;
        count_d = count_q;
        if (push) begin
            wrSel_d = wrSel_q + 1'b1;
        end
        if (pop) begin
            rdSel_d = rdSel_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Selector and count registers, cleared by synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrSel_q <= '0;
            rdSel_q <= '0;
            count_q <= '0;
        end else begin
            wrSel_q <= wrSel_d;
            rdSel_q <= rdSel_d;
            count_q <= count_d;
        end
    end

    for (genvar i = 0; i < N_BANKS; i++) begin : gBank
        localparam logic [SELW-1:0] BANK_ID = SELW'(i);

        logic [WIDTH-1:0] mem [BANK_DEPTH];
        logic [WIDTH-1:0] sramRdata_q;
        logic [PW-1:0]    wrPtr_q, wrPtr_d;
        logic [PW-1:0]    rdPtr_q, rdPtr_d;
        logic [PW-1:0]    sramAddr;
        logic [SCW-1:0]   sramCnt_q, sramCnt_d;
        logic             inflight_q;
        logic [WIDTH-1:0] bufData_q [2];
        logic             bufHead_q, bufHead_d;
        logic [1:0]       bufOcc_q, bufOcc_d;
        logic             bankPush;
        logic             bankPop;
        logic             slotFree;
        logic             bypass;
        logic             sramWrite;
        logic             readIssue;
        logic             bufWrite;
        logic             bufWrIdx;
        logic [WIDTH-1:0] bufWrData;

        assign bankPush = push & (wrSel_q == BANK_ID);
        assign bankPop  = pop & (rdSel_q == BANK_ID);

        // A buffer slot is free only if the entries already held plus any
        // SRAM read still returning leave room; a pop this cycle gives no
        // credit until next cycle.
        assign slotFree = (bufOcc_q == 2'd0) || ((bufOcc_q == 2'd1) && !inflight_q);

        // Bypassing is only allowed with nothing older in the SRAM or in
        // flight, which keeps the per-bank order intact and guarantees a
        // bypass never lands in the same cycle as an SRAM return.
        assign bypass    = bankPush && (sramCnt_q == '0) && !inflight_q && slotFree;
        assign sramWrite = bankPush && !bypass;
        assign readIssue = (sramCnt_q != '0) && slotFree && !bankPush;
        assign sramAddr  = sramWrite ? wrPtr_q : rdPtr_q;

        assign bufWrite  = bypass || inflight_q;
        assign bufWrData = bypass ? data_i : sramRdata_q;
        assign bufWrIdx  = bufHead_q ^ bufOcc_q[0];

        assign bankValid[i] = (bufOcc_q != 2'd0);
        assign bankHead[i]  = bufData_q[bufHead_q];

        // Single-port SRAM: one access per cycle, writes win over reads.
        // Contents survive reset; only the bookkeeping is cleared.
        always_ff @(posedge clk_i) begin
            if (sramWrite) begin
                mem[sramAddr] <= data_i;
            end else if (readIssue) begin
                sramRdata_q <= mem[sramAddr];
            end
        end

        // Next-state for the bank pointers, SRAM fill level and buffer.
        always_comb begin
            wrPtr_d   = wrPtr_q;
            rdPtr_d   = rdPtr_q;
            sramCnt_d = sramCnt_q;
            bufHead_d = bufHead_q;
            bufOcc_d  = bufOcc_q;
            if (sramWrite) begin
                wrPtr_d   = wrPtr_q + 1'b1;
                sramCnt_d = sramCnt_q + 1'b1;
            end
            if (readIssue) begin
                rdPtr_d   = rdPtr_q + 1'b1;
                sramCnt_d = sramCnt_q - 1'b1;
            end
            if (bankPop) begin
                bufHead_d = ~bufHead_q;
            end
            bufOcc_d = bufOcc_q + {1'b0, bufWrite} - {1'b0, bankPop};
        end

        // Per-bank state registers and prefetch buffer storage.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wrPtr_q      <= '0;
                rdPtr_q      <= '0;
                sramCnt_q    <= '0;
                inflight_q   <= 1'b0;
                bufHead_q    <= 1'b0;
                bufOcc_q     <= 2'd0;
                bufData_q[0] <= '0;
                bufData_q[1] <= '0;
            end else begin
                wrPtr_q    <= wrPtr_d;
                rdPtr_q    <= rdPtr_d;
                sramCnt_q  <= sramCnt_d;
                inflight_q <= readIssue;
                bufHead_q  <= bufHead_d;
                bufOcc_q   <= bufOcc_d;
                if (bufWrite) begin
                    bufData_q[bufWrIdx] <= bufWrData;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_singleport_banked.sv
// Testbench for fifo_singleport_banked: directed fill/drain, overflow,
// underflow, bypass, streaming and flag sequences followed by randomized
// traffic with a mid-stream reset. Accepted writes go into an expected-data
// queue; an independent monitor compares every accepted read and the
// count/flag outputs against that queue.
module tb_fifo_singleport_banked;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int NB    = 4;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             wr_valid_i = 1'b0;
    logic             wr_ready_o;
    logic [WIDTH-1:0] data_i = '0;
    logic             rd_valid_o;
    logic             rd_ready_i = 1'b0;
    logic [WIDTH-1:0] data_o;
    logic [4:0]       count_o;
    logic             almost_full_o;
    logic             almost_empty_o;

    logic [WIDTH-1:0] expQ [$];
    int checks = 0;
    int errors = 0;

    fifo_singleport_banked #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .N_BANKS(NB), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .data_i(data_i),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .data_o(data_o),
        .count_o(count_o), .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs and record an accepted write in the scoreboard.
    task automatic applyStimulus(input logic wv, input logic [WIDTH-1:0] d, input logic rr);
        @(posedge clk_i);
        #1;
        wr_valid_i = wv;
        data_i     = d;
        rd_ready_i = rr;
        @(negedge clk_i);
        #1;
        if (wr_valid_i && wr_ready_o && !rst_i) begin
            expQ.push_back(data_i);
        end
    endtask

    // Two-cycle reset; reset values are checked while reset is still held.
    task automatic doReset();
        @(posedge clk_i);
        #1;
        rst_i      = 1'b1;
        wr_valid_i = 1'b0;
        rd_ready_i = 1'b0;
        expQ.delete();
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("rst wr_ready", wr_ready_o, 1);
        checkOutput("rst rd_valid", rd_valid_o, 0);
        checkOutput("rst data_o", data_o, 0);
        checkOutput("rst count", count_o, 0);
        checkOutput("rst almost_full", almost_full_o, 0);
        checkOutput("rst almost_empty", almost_empty_o, 1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // Monitor: compare every accepted read and the count/flags against the queue.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                int n;
                n = expQ.size();
                checkOutput("count", count_o, n);
                checkOutput("wr_ready", wr_ready_o, n < DEPTH);
                checkOutput("almost_full", almost_full_o, n >= AF);
                checkOutput("almost_empty", almost_empty_o, n <= AE);
                if (!rd_valid_o) begin
                    checkOutput("data_o idle", data_o, 0);
                end
                if (n == 0) begin
                    checkOutput("rd_valid while empty", rd_valid_o, 0);
                end else if (rd_valid_o && rd_ready_i) begin
                    logic [WIDTH-1:0] exp;
                    exp = expQ.pop_front();
                    checkOutput("pop data", data_o, exp);
                end
            end
        end
    end

    // Main stimulus sequence.
    initial begin
        int pw;
        int pr;
        doReset();

        // Bypass latency: visible the cycle after the push edge.
        applyStimulus(1'b1, 8'h5C, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("bypass rd_valid", rd_valid_o, 1);
        checkOutput("bypass data", data_o, 8'h5C);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Fill with 0x00..0x0F, watching the flags along the way.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, WIDTH'(i), 1'b0);
            checkOutput("fill almost_empty", almost_empty_o, i <= AE);
            checkOutput("fill almost_full", almost_full_o, i >= AF);
        end

        // Overflow attempt while full.
        applyStimulus(1'b1, 8'hAA, 1'b0);
        checkOutput("full wr_ready", wr_ready_o, 0);
        checkOutput("full count", count_o, 16);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("overflow ignored count", count_o, 16);

        // Full boundary: push attempt and pop together leaves one slot free.
        applyStimulus(1'b1, 8'hBB, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("boundary count", count_o, 15);
        checkOutput("boundary wr_ready", wr_ready_o, 1);

        // Drain everything, then keep reading while empty.
        repeat (20) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("drained rd_valid", rd_valid_o, 0);
        checkOutput("drained data_o", data_o, 0);
        checkOutput("underflow count", count_o, 0);
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Streaming: one preload, then 100 cycles of push and pop together.
        applyStimulus(1'b1, 8'h00, 1'b0);
        for (int k = 1; k <= 100; k++) begin
            applyStimulus(1'b1, WIDTH'(k), 1'b1);
            checkOutput("stream rd_valid", rd_valid_o, 1);
            checkOutput("stream count", count_o, 1);
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Random traffic in fill-biased, drain-biased and balanced phases,
        // with a reset in the middle.
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (cyc == 2500) begin
                doReset();
            end
            case ((cyc / 300) % 3)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 30; pr = 80; end
                default: begin pw = 50; pr = 50; end
            endcase
            applyStimulus($urandom_range(0, 99) < pw, WIDTH'($urandom), $urandom_range(0, 99) < pr);
        end

        repeat (40) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("final count", count_o, 0);
        applyStimulus(1'b0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_singleport_banked.md
# fifo_singleport_banked

Parametrised FIFO built from N_BANKS single-port SRAM banks (`sram_singleport`) plus a 2-entry `fifo_dff` prefetch buffer per bank. Writes and reads rotate round-robin across the banks, so a full-rate push and pop can run every cycle even though each bank has only one port. It extends the two-bank single-port FIFO with four additions:

- a generic bank count;
- valid/ready handshakes that reject overflow and underflow;
- an occupancy count;
- programmable almost-full and almost-empty flags.

## Interface

- WIDTH, 8: data width in bits.
- DEPTH, 16: total capacity in entries, including entries held in the prefetch buffers.
- N_BANKS, 2: number of SRAM banks. Must be a power of 2 and ≥2.
- AF_THRESH, DEPTH-2: almost_full_o asserts when count ≥ AF_THRESH.
- AE_THRESH, 2: almost_empty_o asserts when count ≤ AE_THRESH.
- Derived parameter BANK_DEPTH = DEPTH/N_BANKS. It must be a power of 2 and ≥2.

Ports:

- clk_i  in  1  the single clock; all logic is on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- wr_valid_i  in  1  write request.
- wr_ready_o  out  1  FIFO can accept a write; equals count_o < DEPTH.
- data_i  in  WIDTH  write data.
- rd_valid_o  out  1  head entry is available on data_o.
- rd_ready_i  in  1  consumer accepts the head entry.
- data_o  out  WIDTH  head entry, first-word fall-through; forced to 0 when rd_valid_o=0.
- count_o  out  $clog2(DEPTH+1)  number of stored entries.
- almost_full_o  out  1  count_o ≥ AF_THRESH.
- almost_empty_o  out  1  count_o ≤ AE_THRESH.

## Operation

- **Handshakes.** push = wr_valid_i & wr_ready_o. pop = rd_valid_o & rd_ready_i. A write while full and a read while not valid are ignored: no state changes.
- **Bank selection.** wr_sel and rd_sel are $clog2(N_BANKS)-bit counters. wr_sel increments on push, rd_sel increments on pop, and both wrap from N_BANKS-1 to 0. Entry k of the stream therefore lives in bank k mod N_BANKS.
- **Per-bank state.**
  - wr_ptr and rd_ptr, each $clog2(BANK_DEPTH) bits, wrapping BANK_DEPTH-1→0.
  - sram_cnt: number of entries in the SRAM, range 0..BANK_DEPTH.
  - inflight: SRAM read issued last cycle.
  - buf_occ: prefetch buffer occupancy, 0..2.
  - slot_free = (buf_occ + inflight) < 2, computed from registered state only. A pop in the same cycle gives no credit.
- **Write path for bank i** (push with wr_sel=i):
  - Bypass: if sram_cnt=0, inflight=0 and slot_free, data_i goes straight into the buffer.
  - Otherwise data_i is written to the SRAM at wr_ptr, and wr_ptr and sram_cnt advance.
- **Read issue for bank i.**
  - A read is issued when sram_cnt>0, slot_free, and the bank is not being written this cycle. A write always has priority on the single port.
  - The SRAM address is wr_ptr on a write and rd_ptr otherwise.
  - On issue, rd_ptr advances, sram_cnt decrements and inflight is set.
  - The next cycle the SRAM output is written into the buffer.
  - A bypass and an in-flight SRAM return never coincide in the same bank.
- **Ordering.** Bypass only with an empty SRAM and nothing in flight, so per-bank order is preserved. Round-robin selection preserves global order.
- **Output.**
  - rd_valid_o is high when the buffer of bank rd_sel is non-empty.
  - data_o is the head of that buffer.
  - A pop reads that buffer.
- **Count.** push & ~pop gives +1; pop & ~push gives -1; otherwise unchanged. The count never exceeds DEPTH and never underflows.
- **Flags.** Both flags are combinational from the count register.

## Timing

- **Reset values.** While rst_i is high and on the first cycle after it:
  - wr_ready_o=1, rd_valid_o=0, data_o=0, count_o=0, almost_full_o=0, almost_empty_o=1.
  - All pointers, sram_cnt, inflight, buffers, wr_sel and rd_sel are cleared.
- **Reset mid-operation.** Reset discards all contents and takes effect in the cycle rst_i is sampled high. SRAM contents are not cleared.
- **Bypass latency.** A push at edge t into an empty bank gives rd_valid_o=1 with the data from cycle t+1.
- **SRAM-path latency.**
  - Read issued at edge r.
  - Data enters the buffer at edge r+1.
  - Data is visible on data_o from r+1 onward, once the buffer register has updated.
- **Count and flags.** count_o and both flags update one cycle after the handshake edge.
- **Full boundary.**
  - wr_ready_o does not depend on same-cycle rd_ready_i.
  - When full, a simultaneous push attempt and pop leaves one entry free next cycle, with count = DEPTH-1.
- **Throughput.** With continuous push and pop and count ≥ 1, rd_valid_o stays high and one entry moves per cycle with no bubbles, for N_BANKS ≥ 2.
- **Wrap-around.** Pointer wrap at BANK_DEPTH-1 and bank-select wrap at N_BANKS-1 cause no bubble or reorder.

## Test plan

- **Reset / fill / drain.** WIDTH=8, DEPTH=16, N_BANKS=4. Push 0x00..0x0F back-to-back.
  - wr_ready_o falls after the 16th push and count_o=16.
  - Pop all: output order is 0x00..0x0F, then rd_valid_o=0, data_o=0, count_o=0.
- **Overflow / underflow.**
  - A 17th push of 0xAA while full is ignored: count_o stays 16 and 0xAA never appears.
  - rd_ready_i=1 while empty leaves count_o at 0.
- **Streaming.** After one preload push, run 100 cycles of simultaneous push and pop with an incrementing pattern.
  - rd_valid_o stays 1, the output is in order with no gaps, and count_o stays 1.
- **Bypass latency.** Push 0x5C into an empty FIFO at edge t.
  - rd_valid_o=1 and data_o=0x5C at cycle t+1.
- **Flags.** With AF_THRESH=14 and AE_THRESH=2, push entries one at a time.
  - almost_empty_o falls when count_o reaches 3.
  - almost_full_o rises when count_o reaches 14.
- **Random and reset.** Random valid/ready for 5,000 cycles, checked against a reference queue, with rst_i asserted mid-stream at cycle 2,500.
  - All outputs return to their reset values and the queue restarts empty.
